// File: rtl/xcorr_peak.sv
// ============================================================================
//  Module      : xcorr_peak
//  Description : Peak search over the cross-correlator output memory. When a
//                scan starts, the block reads all 2^OUT_ADDR_WIDTH terms
//                through the RAM read port. It keeps the first strict maximum
//                of the metric, then reports that peak's index, value and
//                signed sample lag (2*index - N).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OUT_ADDR_WIDTH : correlation memory address width, N = 2^OUT_ADDR_WIDTH
//    DATA_WIDTH     : width of one unsigned correlation term
//  Ports
//    clk        in   system clock, posedge
//    reset_n    in   asynchronous active-low reset
//    start      in   scan request, accepted only in IDLE
//    s_addr     out  RAM read address
//    s_data     in   RAM read data, valid one cycle after s_addr
//    min_level  in   detection threshold, latched on accepted start
//    busy       out  scan in progress (SCAN/DRAIN)
//    done       out  one-cycle completion pulse; results valid from here on
//    found      out  peak_value >= latched min_level
//    peak_index out  index of the maximum metric
//    peak_value out  metric at peak_index
//    lag        out  signed lag 2*peak_index - N
//  Build option
//    XCORR_PEAK_SMOOTH_EN : when defined, the metric is s(k-1)+2s(k)+s(k+1).
//                           When undefined, the metric is the raw term.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module xcorr_peak #(
    parameter int OUT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    output logic [OUT_ADDR_WIDTH-1:0]   s_addr,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic [DATA_WIDTH+1:0]       min_level,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [OUT_ADDR_WIDTH-1:0]   peak_index,
    output logic [DATA_WIDTH+1:0]       peak_value,
    output logic [OUT_ADDR_WIDTH+1:0]   lag
);

    localparam int MW = DATA_WIDTH + 2;
    localparam int LW = OUT_ADDR_WIDTH + 2;
    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_ADDR = '1;
    // N expressed in the lag width: 2'b01 followed by OUT_ADDR_WIDTH zeros
    localparam logic [LW-1:0] N_EXT = {2'b01, {OUT_ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [OUT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MW-1:0]             min_q, min_d;
    logic [MW-1:0]             best_val_q, best_val_d;
    logic [OUT_ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
    // Marks the cycle in which s_data carries the term at rd_idx_q
    logic                      rd_vld_q, rd_vld_d;
    logic [OUT_ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [OUT_ADDR_WIDTH-1:0] pk_idx_q, pk_idx_d;
    logic [MW-1:0]             pk_val_q, pk_val_d;
    logic                      found_q, found_d;
    logic [LW-1:0]             lag_q, lag_d;

    logic                      w_accept;
    logic                      w_cmp_vld;
    logic [OUT_ADDR_WIDTH-1:0] w_cmp_idx;
    logic [MW-1:0]             w_metric;
    logic                      w_drain_last;

    assign w_accept = (state_q == ST_IDLE) && start;

`ifdef XCORR_PEAK_SMOOTH_EN
    // Three-term window: the live s_data is the newest term s(k+1), and
    // win1/win2 hold s(k) and s(k-1). The window is cleared on start, so the
    // k=0 left neighbour is 0. The k=N-1 right neighbour is masked because
    // no read is in flight during the second drain cycle.
    logic [DATA_WIDTH-1:0]     win1_q, win1_d;
    logic [DATA_WIDTH-1:0]     win2_q, win2_d;
    logic                      cmp_vld_q, cmp_vld_d;
    logic [OUT_ADDR_WIDTH-1:0] cmp_idx_q, cmp_idx_d;
    logic                      drain_cnt_q, drain_cnt_d;
    logic [DATA_WIDTH-1:0]     w_newest;

    assign w_newest     = rd_vld_q ? s_data : '0;
    assign w_metric     = {2'b00, win2_q} + {1'b0, win1_q, 1'b0} + {2'b00, w_newest};
    assign w_cmp_vld    = cmp_vld_q;
    assign w_cmp_idx    = cmp_idx_q;
    assign w_drain_last = drain_cnt_q;

    always_comb begin
        win1_d      = win1_q;
        win2_d      = win2_q;
        cmp_vld_d   = rd_vld_q;
        cmp_idx_d   = rd_idx_q;
        drain_cnt_d = (state_q == ST_DRAIN) ? ~drain_cnt_q : 1'b0;
        if (w_accept) begin
            win1_d = '0;
            win2_d = '0;
        end else if (rd_vld_q) begin
            win1_d = s_data;
            win2_d = win1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win1_q      <= '0;
            win2_q      <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_idx_q   <= '0;
            drain_cnt_q <= 1'b0;
        end else begin
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_idx_q   <= cmp_idx_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end
`else
    assign w_metric     = {2'b00, s_data};
    assign w_cmp_vld    = rd_vld_q;
    assign w_cmp_idx    = rd_idx_q;
    assign w_drain_last = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                 state_d = ST_SCAN;
            ST_SCAN:  if (addr_q == LAST_ADDR)   state_d = ST_DRAIN;
            ST_DRAIN: if (w_drain_last)          state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        // Address wraps from N-1 back to 0 on entry to DRAIN.
        addr_d     = (state_q == ST_SCAN) ? addr_q + 1'b1 : '0;
        rd_vld_d   = (state_q == ST_SCAN);
        rd_idx_d   = addr_q;
        min_d      = w_accept ? min_level : min_q;

        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (w_accept) begin
            best_val_d = '0;
            best_idx_d = '0;
        end else if (w_cmp_vld && (w_metric > best_val_q)) begin
            // Strict compare: on a tie, the earlier (lower) index is kept.
            best_val_d = w_metric;
            best_idx_d = w_cmp_idx;
        end

        pk_idx_d = pk_idx_q;
        pk_val_d = pk_val_q;
        found_d  = found_q;
        lag_d    = lag_q;
        // The last compare lands on the same edge that enters DONE, so the
        // results are taken from the next-state best values. This makes
        // them visible during the DONE cycle.
        if ((state_q == ST_DRAIN) && w_drain_last) begin
            pk_idx_d = best_idx_d;
            pk_val_d = best_val_d;
            found_d  = (best_val_d >= min_q);
            lag_d    = {1'b0, best_idx_d, 1'b0} - N_EXT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            min_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            pk_idx_q   <= '0;
            pk_val_q   <= '0;
            found_q    <= 1'b0;
            lag_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            min_q      <= min_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            pk_idx_q   <= pk_idx_d;
            pk_val_q   <= pk_val_d;
            found_q    <= found_d;
            lag_q      <= lag_d;
        end
    end

    assign s_addr     = addr_q;
    assign peak_index = pk_idx_q;
    assign peak_value = pk_val_q;
    assign found      = found_q;
    assign lag        = lag_q;

endmodule

`default_nettype wire
